// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: latches a pattern on start and shifts it out MSB-first
// with programmable repetitions and inter-repetition gap. Define SEQ_TX_PARITY_EN to add an even-parity bit per pattern.
module seq_pattern_tx #(
  parameter int unsigned PATTERN_W  = 4,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned GAP_W      = 4,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_a_p,
  input  logic                 start,
  input  logic [PATTERN_W-1:0] pattern,
  input  logic [CNT_W-1:0]     repeat_cnt,
  input  logic [GAP_W-1:0]     gap,
  output logic                 ready,
  output logic                 busy,
  output logic                 bit_out,
  output logic                 bit_valid,
  output logic                 done
);

  localparam int unsigned    IDX_W   = (PATTERN_W > 1) ? $clog2(PATTERN_W) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PATTERN_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  state_t               state, state_n;
  logic [PATTERN_W-1:0] pat_q;
  logic [CNT_W-1:0]     reps;
  logic [GAP_W-1:0]     gap_q;
  logic [GAP_W-1:0]     gap_cnt;
  logic [IDX_W-1:0]     idx;
  logic                 last_bit;
  logic                 shift_bit;

`ifdef SEQ_TX_PARITY_EN
  // Parity cycle follows index 0; idx parks at 0 while it is driven.
  logic par_phase;

  always_ff @(posedge clk or posedge rst_a_p) begin
    if (rst_a_p) par_phase <= 1'b0;
    else         par_phase <= (state == SHIFT) && !par_phase && (idx == '0);
  end

  assign last_bit  = par_phase;
  assign shift_bit = par_phase ? ^pat_q : pat_q[idx];
`else
  assign last_bit  = (idx == '0);
  assign shift_bit = pat_q[idx];
`endif

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (start) state_n = (repeat_cnt == '0) ? DONE : SHIFT;
      SHIFT: if (last_bit) begin
               if (reps == CNT_W'(1))  state_n = DONE;
               else if (gap_q == '0)   state_n = SHIFT;
               else                    state_n = GAP;
             end
      GAP:   if (gap_cnt == GAP_W'(1)) state_n = SHIFT;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_a_p) begin
    if (rst_a_p) begin
      state   <= IDLE;
      pat_q   <= '0;
      reps    <= '0;
      gap_q   <= '0;
      gap_cnt <= '0;
      idx     <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (start) begin
          pat_q <= pattern;
          reps  <= repeat_cnt;
          gap_q <= gap;
          idx   <= IDX_TOP;
        end
        SHIFT: begin
          if (last_bit) begin
            reps    <= reps - 1'b1;
            idx     <= IDX_TOP;
            gap_cnt <= gap_q;
          end else if (idx != '0) begin
            idx <= idx - 1'b1;
          end
        end
        GAP:     gap_cnt <= gap_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  assign ready     = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign bit_valid = (state == SHIFT);
  assign bit_out   = bit_valid ? shift_bit : IDLE_LEVEL;

endmodule
